// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token codes, receiver FSM states and a token matcher.
package tmds_pkg;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } tmds_state_e;

  // c holds {c1, c0}
  typedef struct packed {
    logic       valid;
    logic [1:0] c;
  } token_t;

  function automatic token_t is_token(input logic [9:0] win);
    token_t t;
    t.valid = 1'b1;
    t.c     = 2'b00;
    case (win)
      TOKEN_00: t.c = 2'b00;
      TOKEN_01: t.c = 2'b01;
      TOKEN_10: t.c = 2'b10;
      TOKEN_11: t.c = 2'b11;
      default:  t.valid = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_receiver_if.sv
// Bundle for one TMDS lane receiver: serial input plus the decoded word outputs.
interface tmds_channel_receiver_if;
  // word_valid is a one-clock strobe with no backpressure: the sink must take
  // data_out/c0/c1/video_active/ctrl_seen in the cycle word_valid is high.
  logic       serial_in;
  logic       locked;
  logic       word_valid;
  logic       video_active;
  logic [7:0] data_out;
  logic       c0;
  logic       c1;
  logic       ctrl_seen;

  modport master (
    output serial_in,
    input  locked, word_valid, video_active, data_out, c0, c1, ctrl_seen
  );

  modport slave (
    input  serial_in,
    output locked, word_valid, video_active, data_out, c0, c1, ctrl_seen
  );
endinterface

// File: rtl/tmds_decoder.sv
// Combinational 10b->8b TMDS decode and control-token detect; inverse of the transmitter encoder.
module tmds_decoder
  import tmds_pkg::*;
(
  input  logic [9:0] q_i,
  output logic [7:0] data_o,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o
);

  logic [7:0] t;
  token_t     tok;

  always_comb begin
    t = q_i[9] ? ~q_i[7:0] : q_i[7:0];
    data_o[0] = t[0];
    // q[8] says whether the encoder chained with XOR (1) or XNOR (0)
    for (int i = 1; i < 8; i++) begin
      data_o[i] = q_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    tok       = is_token(q_i);
    is_ctrl_o = tok.valid;
    ctrl_o    = tok.c;
  end

endmodule

// File: rtl/tmds_channel_receiver.sv
// One TMDS lane receiver: 1 bit/clk deserialiser, control-token word alignment, 10b->8b decode.
module tmds_channel_receiver
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS  = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tmds_channel_receiver_if.slave bus,
  output tmds_state_e            state_o
);

  localparam int               TW          = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0]    TIMEOUT_MAX = TW'(LOCK_TIMEOUT);
  localparam logic [TW:0]      TIMEOUT_CMP = (TW+1)'(LOCK_TIMEOUT);
  localparam logic [4:0]       LOCK_N      = 5'(LOCK_TOKENS);

  tmds_state_e   state_q, state_d;
  logic [9:0]    shift_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    match_cnt_q, match_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          locked_q, locked_d;
  logic          wv_q, wv_d;
  logic          va_q, va_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    c_q, c_d;
  logic          ctrl_seen_q, ctrl_seen_d;

  logic [9:0] win_next;
  logic       boundary;
  logic       lock_hit;
  logic       timeout_hit;
  logic [7:0] dec_data;
  logic       dec_ctrl;
  logic [1:0] dec_c;

  assign win_next    = {bus.serial_in, shift_q[9:1]};
  assign boundary    = (bit_cnt_q == 4'd9);
  assign lock_hit    = (({1'b0, match_cnt_q} + 5'd1) == LOCK_N);
  assign timeout_hit = (({1'b0, timeout_q} + 1'b1) >= TIMEOUT_CMP);

  tmds_decoder u_dec (
    .q_i       (win_next),
    .data_o    (dec_data),
    .is_ctrl_o (dec_ctrl),
    .ctrl_o    (dec_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (dec_ctrl) state_d = (LOCK_N == 5'd1) ? LOCKED : VERIFY;
      VERIFY:  if (boundary) state_d = dec_ctrl ? (lock_hit ? LOCKED : VERIFY) : HUNT;
      LOCKED:  if (boundary && !dec_ctrl && timeout_hit) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    match_cnt_d = match_cnt_q;
    timeout_d   = timeout_q;
    locked_d    = locked_q;
    wv_d        = 1'b0;
    ctrl_seen_d = 1'b0;
    va_d        = va_q;
    data_d      = data_q;
    c_d         = c_q;
    case (state_q)
      HUNT: begin
        // Any token realigns the word counter to end on this edge
        if (dec_ctrl) begin
          bit_cnt_d   = 4'd0;
          match_cnt_d = 4'd1;
          timeout_d   = '0;
          locked_d    = (LOCK_N == 5'd1);
        end else begin
          match_cnt_d = 4'd0;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (dec_ctrl) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (lock_hit) begin
              locked_d  = 1'b1;
              timeout_d = '0;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (dec_ctrl) begin
            va_d        = 1'b0;
            c_d         = dec_c;
            ctrl_seen_d = 1'b1;
            wv_d        = 1'b1;
            timeout_d   = '0;
          end else if (timeout_hit) begin
            // Too long without a token: drop lock, suppress this word
            timeout_d   = TIMEOUT_MAX;
            locked_d    = 1'b0;
            va_d        = 1'b0;
            match_cnt_d = 4'd0;
          end else begin
            va_d      = 1'b1;
            data_d    = dec_data;
            wv_d      = 1'b1;
            timeout_d = timeout_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      timeout_q   <= '0;
      locked_q    <= 1'b0;
      wv_q        <= 1'b0;
      va_q        <= 1'b0;
      data_q      <= '0;
      c_q         <= '0;
      ctrl_seen_q <= 1'b0;
    end else begin
      shift_q     <= win_next;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
      wv_q        <= wv_d;
      va_q        <= va_d;
      data_q      <= data_d;
      c_q         <= c_d;
      ctrl_seen_q <= ctrl_seen_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.word_valid   = wv_q;
  assign bus.video_active = va_q;
  assign bus.data_out     = data_q;
  assign bus.c1           = c_q[1];
  assign bus.c0           = c_q[0];
  assign bus.ctrl_seen    = ctrl_seen_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Self-checking bench for tmds_channel_receiver: lock, token/data decode, reset, timeout, false lock.
module tb_tmds_channel_receiver;
  import tmds_pkg::*;

  localparam int TIMEOUT_WORDS = 1024;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n;
  tmds_channel_receiver_if bus ();
  tmds_state_e state_o;

  tmds_channel_receiver #(.LOCK_TOKENS(4), .LOCK_TIMEOUT(TIMEOUT_WORDS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  bit have_last  = 1'b0;
  bit spacing_en = 1'b0;
  bit lock_watch = 1'b0;
  bit lock_seen  = 1'b0;
  logic [7:0] m_data;
  logic [1:0] m_c;
  logic [9:0] tk [4];

  typedef struct {
    bit         is_tok;
    logic [1:0] c;
    logic [7:0] d;
    bit         inv;
    logic       exp_va;
    logic [1:0] exp_c;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference TMDS encoder (transition-minimising stage, optional inversion)
  function automatic logic [9:0] encode(input logic [7:0] d, input bit inv);
    int n1 = 0;
    logic [8:0] qm;
    bit use_xnor;
    for (int i = 0; i < 8; i++) n1 += d[i];
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.serial_in = w[i];
    end
  endtask

  task automatic send_bits0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.serial_in = 1'b0;
    end
  endtask

  task automatic send_tok(input int c, input bit expect_strobe);
    if (expect_strobe) begin
      m_c = 2'(c);
      exp_q.push_back({1'b0, 1'b1, m_c, m_data});
    end
    send_word(tk[c]);
  endtask

  task automatic send_data(input logic [7:0] d, input bit inv, input bit expect_strobe);
    if (expect_strobe) begin
      m_data = d;
      exp_q.push_back({1'b1, 1'b0, m_c, m_data});
    end
    send_word(encode(d, inv));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    send_bits0(7);
    for (int i = 0; i < 3; i++) send_tok(0, 1'b0);
    settle();
    check("lock_pending_locked", 32'(bus.locked), 0);
    check("lock_pending_state", 32'(state_o), 32'(VERIFY));
    send_tok(0, 1'b0);
    settle();
    check("lock_4th_token", 32'(bus.locked), 1);
    check("lock_state", 32'(state_o), 32'(LOCKED));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (lock_watch && bus.locked) lock_seen = 1'b1;
    if (rst_n && bus.word_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got word_valid with data %0h, expected no strobe", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        check("word", {20'b0, bus.video_active, bus.ctrl_seen, bus.c1, bus.c0, bus.data_out}, {20'b0, e});
      end
      if (spacing_en && have_last) check("strobe_gap", 32'(cyc - last_cyc), 10);
      have_last = 1'b1;
      last_cyc  = cyc;
    end
    if (bus.ctrl_seen && !bus.word_valid) begin
      n_checks++;
      $display("FAIL ctrl_seen_alone: got ctrl_seen=1 with word_valid=0, expected both or neither");
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    tk[0] = 10'b1101010100;
    tk[1] = 10'b0010101011;
    tk[2] = 10'b0101010100;
    tk[3] = 10'b1010101011;
    //          tok  c      d      inv  va    c      data
    vecs[0] = '{1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[1] = '{1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 2'd1, 8'h00};
    vecs[2] = '{1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 2'd2, 8'h00};
    vecs[3] = '{1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h00};
    vecs[5] = '{1'b0, 2'd0, 8'hFF, 1'b1, 1'b1, 2'd3, 8'hFF};
    vecs[6] = '{1'b0, 2'd0, 8'hA5, 1'b0, 1'b1, 2'd3, 8'hA5};
    vecs[7] = '{1'b0, 2'd0, 8'h10, 1'b1, 1'b1, 2'd3, 8'h10};
    vecs[8] = '{1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h10};
    vecs[9] = '{1'b0, 2'd0, 8'h3C, 1'b0, 1'b1, 2'd0, 8'h3C};

    bus.serial_in = 1'b0;
    m_data = 8'h00;
    m_c    = 2'b00;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {24'b0, bus.locked, bus.word_valid, bus.video_active, bus.ctrl_seen,
                            bus.c1, bus.c0, 2'b0}, 0);
    check("reset_data", 32'(bus.data_out), 0);
    check("reset_state", 32'(state_o), 32'(HUNT));
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on repeated 00 tokens, then two strobed tokens
    lock_up();
    send_tok(0, 1'b1);
    send_tok(0, 1'b1);
    send_data(8'hA5, 1'b0, 1'b1);

    // Reset in the middle of the next word
    begin
      logic [9:0] w;
      w = encode(8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        bus.serial_in = w[i];
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midword_reset_outputs", {24'b0, bus.locked, bus.word_valid, bus.video_active, bus.ctrl_seen,
                                    bus.c1, bus.c0, 2'b0}, 0);
    check("midword_reset_data", 32'(bus.data_out), 0);
    check("midword_reset_state", 32'(state_o), 32'(HUNT));
    check("midword_queue_drained", 32'(exp_q.size()), 0);
    m_data = 8'h00;
    m_c    = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.serial_in = 1'b0;

    // Relock and run the token/data table with strict 10-clock strobe spacing
    lock_up();
    have_last  = 1'b0;
    spacing_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].exp_va, ~vecs[i].exp_va, vecs[i].exp_c, vecs[i].exp_data});
      if (vecs[i].is_tok) send_word(tk[vecs[i].c]);
      else                send_word(encode(vecs[i].d, vecs[i].inv));
    end
    m_data = vecs[9].exp_data;
    m_c    = vecs[9].exp_c;

    // Timeout: one token, then data until the 1024th data word drops lock
    send_tok(0, 1'b1);
    for (int k = 1; k <= TIMEOUT_WORDS; k++) begin
      send_data(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), k < TIMEOUT_WORDS);
      if (k == TIMEOUT_WORDS - 1) begin
        settle();
        check("timeout_still_locked", 32'(bus.locked), 1);
      end
    end
    settle();
    check("timeout_locked_drop", 32'(bus.locked), 0);
    check("timeout_no_strobe", 32'(bus.word_valid), 0);
    check("timeout_video_active", 32'(bus.video_active), 0);
    check("timeout_data_hold", 32'(bus.data_out), 32'(m_data));
    check("timeout_state", 32'(state_o), 32'(HUNT));
    spacing_en = 1'b0;

    // False lock: one token then misaligned data never reaches LOCKED
    send_bits0(20);
    lock_watch = 1'b1;
    send_tok(0, 1'b0);
    settle();
    check("false_lock_verify", 32'(state_o), 32'(VERIFY));
    send_bits0(3);
    for (int i = 0; i < 3; i++) send_data(8'h00, 1'b0, 1'b0);
    settle();
    check("false_lock_state", 32'(state_o), 32'(HUNT));
    check("false_lock_locked", 32'(bus.locked), 0);
    lock_watch = 1'b0;
    check("false_lock_never_locked", 32'(lock_seen), 0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
